// File: rtl/dmem_wait_responder_pkg.sv
// dmem_wait_responder_pkg: shared state encoding, operation codes and default
// sizing for the data-memory wait-state responder and its users.
package dmem_wait_responder_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Latched operation type
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Default geometry and timing, also used by the hazard unit and benches
  localparam int DEF_AW          = 8;
  localparam int DEF_WAIT_CYCLES = 2;

  // Wait counter width covers WAIT_CYCLES up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_wait_responder_if.sv
// dmem_wait_responder_if: MEM-stage data-memory request/response bundle.
// Build macro DMEM_ALIGN_CHECK_EN adds the misalign response flag.
interface dmem_wait_responder_if;

  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign;

  modport master (output memread, memwrite, addr, wdata,
                  input  rdata, ready, stall, misalign);
  modport slave  (input  memread, memwrite, addr, wdata,
                  output rdata, ready, stall, misalign);
`else
  modport master (output memread, memwrite, addr, wdata,
                  input  rdata, ready, stall);
  modport slave  (input  memread, memwrite, addr, wdata,
                  output rdata, ready, stall);
`endif

endinterface

// File: rtl/dmem_wait_responder_sram_1rw.sv
// sram_1rw: synchronous single-port word array with a registered read port.
// The read register only updates on a read enable so it holds between reads.
module sram_1rw #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] rd_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;

  // Array storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wd_i;
  end

  // Read register clears on reset and captures only on a read enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rd_q <= '0;
    else if (re_i) rd_q <= mem_q[idx_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: accepts a MEM-stage request, holds the pipeline for
// WAIT_CYCLES wait states, then completes with a one-cycle ready pulse.
// Build macro DMEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
module dmem_wait_responder
  import dmem_wait_responder_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  dmem_wait_responder_if.slave dmem_io
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             op_q, op_d;
  logic             req;
  logic             accessOk;
  logic             enterResp;
  logic             memWe;
  logic             memRe;
`ifdef DMEM_ALIGN_CHECK_EN
  logic             mis_q, mis_d;
`endif

  assign req = dmem_io.memread | dmem_io.memwrite;

`ifdef DMEM_ALIGN_CHECK_EN
  assign accessOk = ~mis_d;
`else
  assign accessOk = 1'b1;
`endif

  // State, wait counter and latched request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Next state: accept in IDLE, count down in WAIT, single-cycle RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_d    = op_q;
`ifdef DMEM_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = dmem_io.addr[AW+1:2];
          wdata_d = dmem_io.wdata;
          op_d    = dmem_io.memwrite ? OP_WRITE : OP_READ;
          cnt_d   = WAIT_LOAD;
`ifdef DMEM_ALIGN_CHECK_EN
          mis_d   = (dmem_io.addr[1:0] != 2'b00);
`endif
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: array access on the edge into RESP, handshake from state
  always_comb begin
    enterResp     = (state_q != RESP) && (state_d == RESP) && !reset;
    memWe         = enterResp && (op_d == OP_WRITE) && accessOk;
    memRe         = enterResp && (op_d == OP_READ) && accessOk;
    dmem_io.ready = (state_q == RESP);
    dmem_io.stall = !reset && (((state_q == IDLE) && req) || (state_q == WAIT));
`ifdef DMEM_ALIGN_CHECK_EN
    dmem_io.misalign = (state_q == RESP) && mis_q;
`endif
  end

  sram_1rw #(
    .AW (AW),
    .DW (32)
  ) u_sram (
    .clk   (clk),
    .reset (reset),
    .we_i  (memWe),
    .re_i  (memRe),
    .idx_i (idx_d),
    .wd_i  (wdata_d),
    .rd_o  (dmem_io.rdata)
  );

endmodule
